// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: DVP camera capture controller. Brings PCLK/HREF/VSYNC/DATA
// into the i_clk domain, pairs bytes into pixels in one of four formats,
// decimates 1x/2x/4x, and writes pixels with row/column addresses. It also
// counts frames and flags line-length and window errors.
module cam_capture_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int H_WIDTH    = 320,
  parameter int V_WIDTH    = 240,
  parameter int PXL_WIDTH  = 16,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                        i_clk,
  input  logic                        i_n_reset,
  input  logic                        i_start_capture,
  input  logic                        i_abort,
  input  logic                        i_next_frame,
  input  logic                        i_continuous,
  input  logic [1:0]                  i_mode,
  input  logic [1:0]                  i_decim,
  input  logic                        i_PCLK,
  input  logic                        i_VS,
  input  logic                        i_HS,
  input  logic [DATA_WIDTH-1:0]       i_DATA,
  output logic                        o_en_xclk,
  output logic [4:0]                  o_present_state,
  output logic [PXL_WIDTH-1:0]        o_pixel_data,
  output logic [$clog2(H_WIDTH):0]    o_h_addr,
  output logic [$clog2(V_WIDTH):0]    o_v_addr,
  output logic                        o_valid,
  output logic                        o_frame_done,
  output logic [FCNT_WIDTH-1:0]       o_frame_cnt,
  output logic                        o_line_err,
  output logic                        o_overrun
);

  localparam int HA_W  = $clog2(H_WIDTH) + 1;
  localparam int VA_W  = $clog2(V_WIDTH) + 1;
  localparam int SRC_W = 16;
  localparam int WD_W  = 2 * DATA_WIDTH;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_WVF  = 5'b00010;
  localparam logic [4:0] ST_WHR  = 5'b00100;
  localparam logic [4:0] ST_RCV  = 5'b01000;
  localparam logic [4:0] ST_FD   = 5'b10000;

  localparam logic [WD_W-1:0]       MASK_565 = WD_W'(16'hFFFF);
  localparam logic [WD_W-1:0]       MASK_555 = WD_W'(15'h7FFF);
  localparam logic [WD_W-1:0]       MASK_444 = WD_W'(12'hFFF);
  localparam logic [FCNT_WIDTH-1:0] FCNT_ONE = FCNT_WIDTH'(1'b1);
  localparam logic [SRC_W-1:0]      SRC_MAX  = 16'hFFFF;
  localparam logic [SRC_W-1:0]      SRC_ONE  = 16'h0001;

  // Right-justify the assembled byte pair according to the pixel format.
  function automatic logic [PXL_WIDTH-1:0] format_pixel(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] b0,
    input logic [DATA_WIDTH-1:0] b1
  );
    logic [WD_W-1:0] word;
    word = {b0, b1};
    case (mode)
      2'd0:    format_pixel = PXL_WIDTH'(word & MASK_565);
      2'd1:    format_pixel = PXL_WIDTH'(word & MASK_555);
      2'd2:    format_pixel = PXL_WIDTH'(word & MASK_444);
      default: format_pixel = PXL_WIDTH'(b0);
    endcase
  endfunction

  // A saturating increment keeps an over-long line or frame from wrapping
  // back into the window.
  function automatic logic [SRC_W-1:0] sat_inc(input logic [SRC_W-1:0] v);
    sat_inc = (v == SRC_MAX) ? v : v + SRC_ONE;
  endfunction

  logic [4:0]            state_r, state_nxt_s;
  logic                  pclk_meta_r, pclk_sync_r, pclk_prev_r, pclk_rise_r;
  logic                  vs_meta_r, vs_sync_r, vs_prev_r, vs_rise_r, vs_fall_r;
  logic                  hs_meta_r, hs_sync_r, hs_prev_r, hs_rise_r, hs_fall_r;
  logic [DATA_WIDTH-1:0] data_meta_r, data_sync_r, data_d_r;
  logic [1:0]            mode_r, decim_r;
  logic [DATA_WIDTH-1:0] b0_r;
  logic                  toggle_r, had_byte_r;
  logic [SRC_W-1:0]      hs_cnt_r, vs_cnt_r;

  logic                  latch_s, enter_start_s, enter_fd_s;
  logic                  line_start_s, line_end_s, byte_s;
  logic [1:0]            shift_s;
  logic [SRC_W-1:0]      mask_s, line_len_s;
  logic                  keep_s, in_win_s;

  // Two-flop synchronisers plus registered edge pulses; DATA follows PCLK's delay.
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      pclk_meta_r <= 1'b0; pclk_sync_r <= 1'b0; pclk_prev_r <= 1'b0; pclk_rise_r <= 1'b0;
      vs_meta_r   <= 1'b0; vs_sync_r   <= 1'b0; vs_prev_r   <= 1'b0;
      vs_rise_r   <= 1'b0; vs_fall_r   <= 1'b0;
      hs_meta_r   <= 1'b0; hs_sync_r   <= 1'b0; hs_prev_r   <= 1'b0;
      hs_rise_r   <= 1'b0; hs_fall_r   <= 1'b0;
      data_meta_r <= '0;   data_sync_r <= '0;   data_d_r    <= '0;
    end else begin
      pclk_meta_r <= i_PCLK; pclk_sync_r <= pclk_meta_r; pclk_prev_r <= pclk_sync_r;
      pclk_rise_r <= pclk_sync_r & ~pclk_prev_r;
      vs_meta_r   <= i_VS;   vs_sync_r   <= vs_meta_r;   vs_prev_r   <= vs_sync_r;
      vs_rise_r   <= vs_sync_r & ~vs_prev_r;
      vs_fall_r   <= ~vs_sync_r & vs_prev_r;
      hs_meta_r   <= i_HS;   hs_sync_r   <= hs_meta_r;   hs_prev_r   <= hs_sync_r;
      hs_rise_r   <= hs_sync_r & ~hs_prev_r;
      hs_fall_r   <= ~hs_sync_r & hs_prev_r;
      data_meta_r <= i_DATA; data_sync_r <= data_meta_r; data_d_r    <= data_sync_r;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides every event, VSYNC rise beats HREF.
  always_comb begin
    state_nxt_s = state_r;
    if (i_abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (i_start_capture) state_nxt_s = ST_WVF; else state_nxt_s = ST_IDLE;
        ST_WVF:  if (vs_fall_r)       state_nxt_s = ST_WHR; else state_nxt_s = ST_WVF;
        ST_WHR: begin
          if (vs_rise_r)      state_nxt_s = ST_FD;
          else if (hs_rise_r) state_nxt_s = ST_RCV;
          else                state_nxt_s = ST_WHR;
        end
        ST_RCV: begin
          if (vs_rise_r)      state_nxt_s = ST_FD;
          else if (hs_fall_r) state_nxt_s = ST_WHR;
          else                state_nxt_s = ST_RCV;
        end
        ST_FD: begin
          if (i_continuous || i_next_frame) state_nxt_s = ST_WVF;
          else                              state_nxt_s = ST_FD;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Transition strobes and decimation/window decode for the datapath.
  always_comb begin
    latch_s       = (state_nxt_s == ST_WVF) && (state_r != ST_WVF);
    enter_start_s = (state_r == ST_IDLE) && (state_nxt_s == ST_WVF);
    enter_fd_s    = (state_nxt_s == ST_FD) && (state_r != ST_FD);
    line_start_s  = (state_r == ST_WHR) && (state_nxt_s == ST_RCV);
    line_end_s    = (state_r == ST_RCV) && (state_nxt_s == ST_WHR);
    // A byte only counts when the line stays open, so HS fall, VS rise and abort drop it.
    byte_s        = (state_r == ST_RCV) && (state_nxt_s == ST_RCV) && pclk_rise_r;
    case (decim_r)
      2'd0:    begin shift_s = 2'd0; mask_s = 16'h0000; end
      2'd1:    begin shift_s = 2'd1; mask_s = 16'h0001; end
      default: begin shift_s = 2'd2; mask_s = 16'h0003; end
    endcase
    line_len_s = SRC_W'(H_WIDTH) << shift_s;
    keep_s     = ((hs_cnt_r & mask_s) == 16'h0000) && ((vs_cnt_r & mask_s) == 16'h0000);
    in_win_s   = ((hs_cnt_r >> shift_s) < SRC_W'(H_WIDTH)) &&
                 ((vs_cnt_r >> shift_s) < SRC_W'(V_WIDTH));
  end

  // Datapath: byte pairing, counters, pixel strobe, frame count and sticky flags.
  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      o_en_xclk <= 1'b0; o_pixel_data <= '0; o_h_addr <= '0; o_v_addr <= '0;
      o_valid <= 1'b0; o_frame_done <= 1'b0; o_frame_cnt <= '0;
      o_line_err <= 1'b0; o_overrun <= 1'b0;
      mode_r <= 2'd0; decim_r <= 2'd0; b0_r <= '0;
      toggle_r <= 1'b0; had_byte_r <= 1'b0; hs_cnt_r <= '0; vs_cnt_r <= '0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      if (latch_s) begin
        mode_r  <= i_mode;
        decim_r <= i_decim;
      end
      if (enter_start_s) begin
        o_en_xclk   <= 1'b1;
        o_frame_cnt <= '0;
        o_overrun   <= 1'b0;
      end else if (i_abort) begin
        o_en_xclk <= 1'b0;
      end
      if (enter_fd_s) begin
        o_frame_done <= 1'b1;
        o_frame_cnt  <= o_frame_cnt + FCNT_ONE;
      end
      if (enter_start_s) begin
        hs_cnt_r <= '0; vs_cnt_r <= '0; toggle_r <= 1'b0; had_byte_r <= 1'b0;
        o_line_err <= 1'b0;
      end else if (vs_rise_r && !i_abort) begin
        hs_cnt_r <= '0; vs_cnt_r <= '0; toggle_r <= 1'b0; had_byte_r <= 1'b0;
      end else if (line_start_s) begin
        hs_cnt_r <= '0; toggle_r <= 1'b0; had_byte_r <= 1'b0;
      end else if (line_end_s) begin
        vs_cnt_r <= sat_inc(vs_cnt_r);
        hs_cnt_r <= '0;
        toggle_r <= 1'b0;
        if (had_byte_r && (hs_cnt_r != line_len_s)) o_line_err <= 1'b1;
      end else if (byte_s) begin
        had_byte_r <= 1'b1;
        if (!toggle_r) begin
          b0_r     <= data_d_r;
          toggle_r <= 1'b1;
        end else begin
          toggle_r <= 1'b0;
          hs_cnt_r <= sat_inc(hs_cnt_r);
          if (keep_s && in_win_s) begin
            o_valid      <= 1'b1;
            o_pixel_data <= format_pixel(mode_r, b0_r, data_d_r);
            o_h_addr     <= HA_W'(hs_cnt_r >> shift_s);
            o_v_addr     <= VA_W'(vs_cnt_r >> shift_s);
          end else if (keep_s) begin
            o_overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign o_present_state = state_r;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: drives DVP pin waveforms at PCLK = i_clk/4.
// Expected pixels go to a scoreboard queue as bytes are driven, and a
// monitor pops and compares them whenever o_valid is seen.
module tb_cam_capture_ctrl;

  localparam int HW = 4;
  localparam int VW = 3;

  logic        i_clk = 1'b0;
  logic        i_n_reset, i_start_capture, i_abort, i_next_frame, i_continuous;
  logic [1:0]  i_mode, i_decim;
  logic        i_PCLK, i_VS, i_HS;
  logic [7:0]  i_DATA;
  logic        o_en_xclk, o_valid, o_frame_done, o_line_err, o_overrun;
  logic [4:0]  o_present_state;
  logic [15:0] o_pixel_data, o_frame_cnt;
  logic [2:0]  o_h_addr, o_v_addr;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  h;
    logic [2:0]  v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fd_cnt = 0;
  int   val_cnt = 0;

  cam_capture_ctrl #(.DATA_WIDTH(8), .H_WIDTH(HW), .V_WIDTH(VW), .PXL_WIDTH(16),
                     .FCNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_n_reset(i_n_reset), .i_start_capture(i_start_capture),
    .i_abort(i_abort), .i_next_frame(i_next_frame), .i_continuous(i_continuous),
    .i_mode(i_mode), .i_decim(i_decim), .i_PCLK(i_PCLK), .i_VS(i_VS), .i_HS(i_HS),
    .i_DATA(i_DATA), .o_en_xclk(o_en_xclk), .o_present_state(o_present_state),
    .o_pixel_data(o_pixel_data), .o_h_addr(o_h_addr), .o_v_addr(o_v_addr),
    .o_valid(o_valid), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_line_err(o_line_err), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Scoreboard monitor: every o_valid must match the oldest expected pixel.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_frame_done === 1'b1) fd_cnt++;
    if (o_valid === 1'b1) begin
      val_cnt++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data=%h h=%0d v=%0d, required no o_valid",
                 o_pixel_data, o_h_addr, o_v_addr);
      end else begin
        e = sb.pop_front();
        if (o_pixel_data !== e.d || o_h_addr !== e.h || o_v_addr !== e.v) begin
          n_err++;
          $display("FAIL sb_pixel: got data=%h h=%0d v=%0d, required data=%h h=%0d v=%0d",
                   o_pixel_data, o_h_addr, o_v_addr, e.d, e.h, e.v);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic pulse_start();
    @(negedge i_clk); i_start_capture = 1'b1;
    @(negedge i_clk); i_start_capture = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge i_clk); i_abort = 1'b1;
    @(negedge i_clk); i_abort = 1'b0;
  endtask

  task automatic vs_high();
    i_VS = 1'b1; wait_clk(8);
  endtask

  task automatic vs_low();
    i_VS = 1'b0; wait_clk(8);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    @(negedge i_clk); i_DATA = b; i_PCLK = 1'b0;
    wait_clk(2);      i_PCLK = 1'b1;
    wait_clk(1);
  endtask

  task automatic line_begin();
    @(negedge i_clk); i_HS = 1'b1; wait_clk(4);
  endtask

  task automatic line_end();
    wait_clk(4); i_HS = 1'b0; wait_clk(8);
  endtask

  // Independent model of decimation, window and format for one line of bytes base+i.
  task automatic send_line(input int nbytes, input int row, input int d, input int mode,
                           input logic [7:0] base);
    int   m;
    exp_t e;
    logic [7:0] b0, b1;
    m = (1 << d) - 1;
    for (int p = 0; p < nbytes / 2; p++) begin
      b0 = base + 8'(2 * p);
      b1 = base + 8'(2 * p + 1);
      if ((p & m) == 0 && (row & m) == 0 && (p >> d) < HW && (row >> d) < VW) begin
        case (mode)
          0:       e.d = {b0, b1};
          1:       e.d = {b0, b1} & 16'h7FFF;
          2:       e.d = {b0, b1} & 16'h0FFF;
          default: e.d = {8'h00, b0};
        endcase
        e.h = 3'(p >> d);
        e.v = 3'(row >> d);
        sb.push_back(e);
      end
    end
    line_begin();
    for (int i = 0; i < nbytes; i++) cam_byte(base + 8'(i));
    line_end();
  endtask

  task automatic test_reset();
    i_n_reset = 1'b0; wait_clk(3);
    n_cmp++;
    if (o_present_state !== 5'b00001) begin
      n_err++; $display("FAIL reset_state: got %b, required 00001", o_present_state);
    end
    n_cmp++;
    if ({o_en_xclk, o_valid, o_frame_done, o_line_err, o_overrun, o_pixel_data,
         o_h_addr, o_v_addr, o_frame_cnt} !== 43'd0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    i_n_reset = 1'b1; wait_clk(2);
  endtask

  task automatic test_mode0_single();
    int fd0;
    i_mode = 2'd0; i_decim = 2'd0; i_continuous = 1'b0;
    fd0 = fd_cnt;
    pulse_start(); wait_clk(1);
    n_cmp++;
    if (o_present_state !== 5'b00010 || o_en_xclk !== 1'b1) begin
      n_err++; $display("FAIL start_state: got %b en=%b, required 00010 en=1",
                        o_present_state, o_en_xclk);
    end
    vs_high(); vs_low();
    for (int r = 0; r < 3; r++) send_line(8, r, 0, 0, 8'h01);
    vs_high();
    n_cmp++;
    if (fd_cnt - fd0 !== 1 || o_frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL mode0_frame: got pulses=%0d cnt=%0d, required 1 1",
                        fd_cnt - fd0, o_frame_cnt);
    end
    n_cmp++;
    if (o_line_err !== 1'b0 || o_overrun !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL mode0_flags: got err=%b ovr=%b left=%0d, required 0 0 0",
                        o_line_err, o_overrun, sb.size());
    end
    wait_clk(10);
    n_cmp++;
    if (o_present_state !== 5'b10000) begin
      n_err++; $display("FAIL single_hold: got %b, required 10000", o_present_state);
    end
    @(negedge i_clk); i_next_frame = 1'b1;
    @(negedge i_clk); i_next_frame = 1'b0;
    n_cmp++;
    if (o_present_state !== 5'b00010) begin
      n_err++; $display("FAIL next_frame: got %b, required 00010", o_present_state);
    end
    pulse_abort();
  endtask

  task automatic test_modes();
    i_mode = 2'd3; i_decim = 2'd0;
    pulse_start(); vs_high(); vs_low();
    send_line(2, 0, 0, 3, 8'hAB);
    pulse_abort();
    i_mode = 2'd2;
    pulse_start();
    n_cmp++;
    if (o_line_err !== 1'b0) begin
      n_err++; $display("FAIL start_clears_err: got %b, required 0", o_line_err);
    end
    vs_high(); vs_low();
    send_line(2, 0, 0, 2, 8'hAB);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL modes_drain: got %0d left, required 0", sb.size());
    end
    pulse_abort();
  endtask

  task automatic test_decim();
    int v0;
    i_mode = 2'd0; i_decim = 2'd1;
    pulse_start(); vs_high(); vs_low();
    v0 = val_cnt;
    for (int r = 0; r < 6; r++) send_line(16, r, 1, 0, 8'h10 + 8'(r * 16));
    n_cmp++;
    if (val_cnt - v0 !== 12 || o_line_err !== 1'b0 || o_overrun !== 1'b0) begin
      n_err++; $display("FAIL decim2x: got valid=%0d err=%b ovr=%b, required 12 0 0",
                        val_cnt - v0, o_line_err, o_overrun);
    end
    vs_high();
    n_cmp++;
    if (o_frame_cnt !== 16'd1) begin
      n_err++; $display("FAIL decim_cnt: got %0d, required 1", o_frame_cnt);
    end
    pulse_abort();
  endtask

  task automatic test_errors();
    int v0;
    i_mode = 2'd0; i_decim = 2'd0;
    pulse_start(); vs_high(); vs_low();
    v0 = val_cnt;
    send_line(6, 0, 0, 0, 8'h21);
    n_cmp++;
    if (o_line_err !== 1'b1 || o_overrun !== 1'b0) begin
      n_err++; $display("FAIL short_line: got err=%b ovr=%b, required 1 0", o_line_err, o_overrun);
    end
    for (int r = 1; r < 5; r++) send_line(8, r, 0, 0, 8'h31);
    n_cmp++;
    if (val_cnt - v0 !== 11 || o_overrun !== 1'b1 || o_line_err !== 1'b1) begin
      n_err++; $display("FAIL overrun: got valid=%0d ovr=%b err=%b, required 11 1 1",
                        val_cnt - v0, o_overrun, o_line_err);
    end
    vs_high();
    pulse_abort(); pulse_start();
    n_cmp++;
    if (o_line_err !== 1'b0 || o_overrun !== 1'b0) begin
      n_err++; $display("FAIL flag_clear: got err=%b ovr=%b, required 0 0", o_line_err, o_overrun);
    end
    pulse_abort();
  endtask

  task automatic test_continuous();
    int fd0;
    i_mode = 2'd0; i_decim = 2'd0; i_continuous = 1'b1;
    fd0 = fd_cnt;
    pulse_start(); vs_high(); vs_low();
    for (int f = 0; f < 3; f++) begin
      send_line(8, 0, 0, 0, 8'h41);
      vs_high(); vs_low();
    end
    n_cmp++;
    if (o_frame_cnt !== 16'd3 || fd_cnt - fd0 !== 3) begin
      n_err++; $display("FAIL continuous: got cnt=%0d pulses=%0d, required 3 3",
                        o_frame_cnt, fd_cnt - fd0);
    end
    n_cmp++;
    if (o_present_state !== 5'b00100) begin
      n_err++; $display("FAIL cont_rearm: got %b, required 00100", o_present_state);
    end
    i_continuous = 1'b0;
    pulse_abort();
  endtask

  task automatic test_abort_midline();
    int   v0;
    exp_t e;
    pulse_start(); vs_high(); vs_low();
    v0 = val_cnt;
    e.d = 16'h0102; e.h = 3'd0; e.v = 3'd0; sb.push_back(e);
    line_begin();
    cam_byte(8'h01); cam_byte(8'h02); cam_byte(8'h03);
    wait_clk(3);
    pulse_abort();
    n_cmp++;
    if (o_present_state !== 5'b00001 || o_en_xclk !== 1'b0) begin
      n_err++; $display("FAIL abort: got %b en=%b, required 00001 en=0", o_present_state, o_en_xclk);
    end
    for (int i = 4; i <= 8; i++) cam_byte(8'(i));
    line_end();
    n_cmp++;
    if (val_cnt - v0 !== 1 || sb.size() != 0) begin
      n_err++; $display("FAIL abort_quiet: got valid=%0d left=%0d, required 1 0",
                        val_cnt - v0, sb.size());
    end
  endtask

  task automatic test_reset_midpixel();
    int   v0;
    exp_t e;
    pulse_start(); vs_high(); vs_low();
    v0 = val_cnt;
    e.d = 16'h0102; e.h = 3'd0; e.v = 3'd0; sb.push_back(e);
    line_begin();
    cam_byte(8'h01); cam_byte(8'h02); cam_byte(8'h03);
    wait_clk(3);
    i_n_reset = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_en_xclk, o_valid, o_frame_done, o_line_err, o_overrun, o_pixel_data,
         o_h_addr, o_v_addr, o_frame_cnt} !== 43'd0 || o_present_state !== 5'b00001) begin
      n_err++; $display("FAIL reset_mid: got state=%b en=%b data=%h, required 00001 0 0000",
                        o_present_state, o_en_xclk, o_pixel_data);
    end
    i_n_reset = 1'b1;
    for (int i = 4; i <= 8; i++) cam_byte(8'(i));
    line_end();
    n_cmp++;
    if (val_cnt - v0 !== 1 || sb.size() != 0) begin
      n_err++; $display("FAIL reset_quiet: got valid=%0d left=%0d, required 1 0",
                        val_cnt - v0, sb.size());
    end
  endtask

  initial begin
    i_n_reset = 1'b0; i_start_capture = 1'b0; i_abort = 1'b0; i_next_frame = 1'b0;
    i_continuous = 1'b0; i_mode = 2'd0; i_decim = 2'd0;
    i_PCLK = 1'b0; i_VS = 1'b0; i_HS = 1'b0; i_DATA = 8'h00;
    test_reset();
    test_mode0_single();
    test_modes();
    test_decim();
    test_errors();
    test_continuous();
    test_abort_midline();
    test_reset_midpixel();
    wait_clk(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
